// File: rtl/dpram_req_ctrl.sv
// Request front-end for a dual-port RAM. Queues upstream writes and reads, issues at
// most one write and one read per cycle on the RAM's separate ports, and returns read
// data in request order. Each queued read records how many older writes are still
// pending and waits for them, so reads always observe earlier writes.
module dpram_req_ctrl #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 1,
  parameter int RSP_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              write_enable,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] data_in,
  output logic              read_enable,
  output logic [ADDR_W-1:0] read_address,
  input  logic [DATA_W-1:0] data_out,
  output logic              idle
);

  localparam int FP_W  = $clog2(FIFO_DEPTH);
  localparam int FC_W  = FP_W + 1;
  localparam int RP_W  = $clog2(RSP_DEPTH);
  localparam int RC_W  = RP_W + 1;
  localparam int SUM_W = $clog2(RSP_DEPTH + RD_LAT + 2) + 1;

  // Write queue
  logic [ADDR_W-1:0] wq_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] wq_data [FIFO_DEPTH];
  logic [FP_W-1:0]   wq_head, wq_tail;
  logic [FC_W-1:0]   wq_cnt, wq_cnt_next;

  // Read queue; rq_ahead counts older writes not yet issued to the RAM
  logic [ADDR_W-1:0] rq_addr  [FIFO_DEPTH];
  logic [FC_W-1:0]   rq_ahead [FIFO_DEPTH];
  logic [FP_W-1:0]   rq_head, rq_tail;
  logic [FC_W-1:0]   rq_cnt;

  // Reads sampled by the RAM whose data has not yet been captured
  logic [RD_LAT-1:0] pipe_v;
  logic [ADDR_W-1:0] pipe_a [RD_LAT];

  // Response buffer
  logic [DATA_W-1:0] rb_data [RSP_DEPTH];
  logic [ADDR_W-1:0] rb_addr [RSP_DEPTH];
  logic [RP_W-1:0]   rb_head, rb_tail;
  logic [RC_W-1:0]   rb_cnt;

  logic             wr_push, wr_pop, rd_push, rd_pop, rsp_push, rsp_pop;
  logic [SUM_W-1:0] in_flight;
  logic             credit_ok;

  // Ready and valid are forced low while reset is held, independent of stale counts.
  assign wr_ready  = rst_n && (wq_cnt != FC_W'(FIFO_DEPTH));
  assign rd_ready  = rst_n && (rq_cnt != FC_W'(FIFO_DEPTH));
  assign wr_push   = wr_valid && wr_ready;
  assign rd_push   = rd_valid && rd_ready;
  assign rsp_push  = pipe_v[RD_LAT-1];
  assign rsp_valid = rst_n && (rb_cnt != '0);
  assign rsp_pop   = rsp_valid && rsp_ready;
  assign rsp_data  = rsp_valid ? rb_data[rb_head] : '0;
  assign rsp_addr  = rsp_valid ? rb_addr[rb_head] : '0;

  // Count reads issued but not yet captured: the read_enable stage plus the latency pipe.
  always_comb begin
    // NOTE: every variable written here gets a value first, so no latch is inferred.
    in_flight = SUM_W'(read_enable);
    for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + SUM_W'(pipe_v[i]);
  end

  // A read issues only when every older write is out and a response slot is reserved,
  // so captured data never has to be stalled.
  assign credit_ok   = (in_flight + SUM_W'(rb_cnt)) < SUM_W'(RSP_DEPTH);
  assign rd_pop      = (rq_cnt != '0) && (rq_ahead[rq_head] == '0) && credit_ok;
  // A younger write to the address being read waits one cycle so the read sees old data.
  assign wr_pop      = (wq_cnt != '0) && !(rd_pop && (wq_addr[wq_head] == rq_addr[rq_head]));
  assign wq_cnt_next = wq_cnt + FC_W'(wr_push) - FC_W'(wr_pop);

  assign idle = rst_n && (wq_cnt == '0) && (rq_cnt == '0) && (in_flight == '0) && (rb_cnt == '0);

  // Entry storage for the queues, latency pipe addresses and response buffer.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays are not reset; counts and valid bits alone decide what is live.
    if (wr_push) begin
      wq_addr[wq_tail] <= wr_addr;
      wq_data[wq_tail] <= wr_data;
    end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (wr_pop && (rq_ahead[i] != '0)) rq_ahead[i] <= rq_ahead[i] - FC_W'(1);
    end
    if (rd_push) begin
      rq_addr[rq_tail]  <= rd_addr;
      rq_ahead[rq_tail] <= wq_cnt_next;
    end
    pipe_a[0] <= read_address;
    for (int i = 1; i < RD_LAT; i++) pipe_a[i] <= pipe_a[i-1];
    if (rsp_push) begin
      rb_data[rb_tail] <= data_out;
      rb_addr[rb_tail] <= pipe_a[RD_LAT-1];
    end
  end

  // Pointers, counts, in-flight valids and the registered RAM interface.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      wq_head       <= '0;
      wq_tail       <= '0;
      wq_cnt        <= '0;
      rq_head       <= '0;
      rq_tail       <= '0;
      rq_cnt        <= '0;
      rb_head       <= '0;
      rb_tail       <= '0;
      rb_cnt        <= '0;
      pipe_v        <= '0;
      write_enable  <= 1'b0;
      write_address <= '0;
      data_in       <= '0;
      read_enable   <= 1'b0;
      read_address  <= '0;
    end else begin
      wq_cnt <= wq_cnt_next;
      if (wr_push) wq_tail <= wq_tail + FP_W'(1);
      if (wr_pop)  wq_head <= wq_head + FP_W'(1);
      rq_cnt <= rq_cnt + FC_W'(rd_push) - FC_W'(rd_pop);
      if (rd_push) rq_tail <= rq_tail + FP_W'(1);
      if (rd_pop)  rq_head <= rq_head + FP_W'(1);
      rb_cnt <= rb_cnt + RC_W'(rsp_push) - RC_W'(rsp_pop);
      if (rsp_push) rb_tail <= rb_tail + RP_W'(1);
      if (rsp_pop)  rb_head <= rb_head + RP_W'(1);
      pipe_v[0] <= read_enable;
      for (int i = 1; i < RD_LAT; i++) pipe_v[i] <= pipe_v[i-1];
      write_enable <= wr_pop;
      if (wr_pop) begin
        write_address <= wq_addr[wq_head];
        data_in       <= wq_data[wq_head];
      end
      read_enable <= rd_pop;
      if (rd_pop) read_address <= rq_addr[rq_head];
    end
  end

endmodule

// File: tb/tb_dpram_req_ctrl.sv
// Bench for dpram_req_ctrl: a RAM model drives data_out, and a program-order memory
// model predicts every response (a read returns the value of all writes accepted before
// it, a same-edge write counting as older).
module tb_dpram_req_ctrl;

  typedef struct packed {
    logic [11:0] a;
    logic [63:0] d;
  } rsp_t;

  logic        clk, rst_n;
  logic        wr_valid, wr_ready, rd_valid, rd_ready, rsp_valid, rsp_ready;
  logic        write_enable, read_enable, idle;
  logic [11:0] wr_addr, rd_addr, rsp_addr, write_address, read_address;
  logic [63:0] wr_data, rsp_data, data_in, data_out;

  logic [63:0] ram     [4096];
  logic [63:0] ref_mem [4096];
  rsp_t        exp_q [$];
  rsp_t        got_q [$];
  int          checks = 0;
  int          errors = 0;
  int          re_cnt = 0;

  dpram_req_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
    .write_enable(write_enable), .write_address(write_address), .data_in(data_in),
    .read_enable(read_enable), .read_address(read_address), .data_out(data_out),
    .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: one-cycle registered read, read returns pre-write data on a same-edge hit.
  always @(posedge clk) begin
    if (write_enable) ram[write_address] <= data_in;
    if (read_enable)  data_out <= ram[read_address];
  end

  // Response and read-issue monitor, sampled mid-cycle.
  always @(negedge clk) begin
    rsp_t r;
    if (rsp_valid && rsp_ready) begin
      r.a = rsp_addr;
      r.d = rsp_data;
      got_q.push_back(r);
    end
    if (read_enable) re_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus; the model is updated for whatever the DUT accepts.
  task automatic drive(input logic wv, input logic [11:0] wa, input logic [63:0] wd,
                       input logic rv, input logic [11:0] ra,
                       output logic wacc, output logic racc);
    rsp_t r;
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    rd_valid = rv; rd_addr = ra;
    wacc = wv && wr_ready;
    racc = rv && rd_ready;
    if (wacc) ref_mem[wa] = wd;
    if (racc) begin
      r.a = ra;
      r.d = ref_mem[ra];
      exp_q.push_back(r);
    end
    tick();
    wr_valid = 1'b0;
    rd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({wr_ready, rd_ready, rsp_valid, idle, write_enable, read_enable} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctl got %b exp 000000",
               {wr_ready, rd_ready, rsp_valid, idle, write_enable, read_enable});
    end
    checks++;
    if (write_address !== 12'h0 || read_address !== 12'h0 || rsp_addr !== 12'h0) begin
      errors++;
      $display("FAIL reset_addr got wa=%h ra=%h rsp=%h exp 0", write_address, read_address, rsp_addr);
    end
    checks++;
    if (data_in !== 64'h0 || rsp_data !== 64'h0) begin
      errors++;
      $display("FAIL reset_data got din=%h rsp=%h exp 0", data_in, rsp_data);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({wr_ready, rd_ready, idle} !== 3'b111) begin
      errors++;
      $display("FAIL reset_release got %b exp 111", {wr_ready, rd_ready, idle});
    end
  endtask

  task automatic test_write_read();
    logic wa_ok, ra_ok;
    drive(1'b1, 12'h005, 64'hDEAD_BEEF_0123_4567, 1'b0, 12'h0, wa_ok, ra_ok);
    checks++;
    if (wa_ok !== 1'b1 || write_enable !== 1'b0) begin
      errors++;
      $display("FAIL wr_accept got acc=%b we=%b exp acc=1 we=0", wa_ok, write_enable);
    end
    tick();
    checks++;
    if (write_enable !== 1'b1 || write_address !== 12'h005 || data_in !== 64'hDEAD_BEEF_0123_4567) begin
      errors++;
      $display("FAIL wr_issue got we=%b a=%h d=%h exp 1 005 deadbeef01234567",
               write_enable, write_address, data_in);
    end
    tick();
    checks++;
    if (write_enable !== 1'b0) begin
      errors++;
      $display("FAIL wr_pulse got we=%b exp 0", write_enable);
    end
    drive(1'b0, 12'h0, 64'h0, 1'b1, 12'h005, wa_ok, ra_ok);
    tick();
    tick();
    checks++;
    if (ra_ok !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_early got acc=%b rsp_valid=%b exp acc=1 rsp_valid=0", ra_ok, rsp_valid);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 64'hDEAD_BEEF_0123_4567 || rsp_addr !== 12'h005) begin
      errors++;
      $display("FAIL rd_latency got v=%b d=%h a=%h exp 1 deadbeef01234567 005",
               rsp_valid, rsp_data, rsp_addr);
    end
    for (int t = 0; t < 50 && got_q.size() < exp_q.size(); t++) tick();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL wr_rd_model got n=%0d exp n=1", got_q.size());
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_same_edge();
    logic wa_ok, ra_ok;
    drive(1'b1, 12'h010, 64'hC, 1'b0, 12'h0, wa_ok, ra_ok);
    repeat (3) tick();
    drive(1'b1, 12'h010, 64'hA, 1'b1, 12'h010, wa_ok, ra_ok);
    for (int t = 0; t < 50 && got_q.size() < 1; t++) tick();
    checks++;
    if (got_q.size() != 1) begin
      errors++;
      $display("FAIL same_edge_count got %0d exp 1", got_q.size());
    end else if (got_q[0].d !== 64'hA || got_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL same_edge_data got %h exp %h", got_q[0].d, 64'hA);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_collision();
    logic wa_ok, ra_ok;
    drive(1'b1, 12'h020, 64'hC, 1'b0, 12'h0, wa_ok, ra_ok);
    drive(1'b1, 12'h032, 64'h55, 1'b0, 12'h0, wa_ok, ra_ok);
    repeat (3) tick();
    // read before a younger write to the same address
    drive(1'b0, 12'h0, 64'h0, 1'b1, 12'h020, wa_ok, ra_ok);
    drive(1'b1, 12'h020, 64'hB, 1'b0, 12'h0, wa_ok, ra_ok);
    for (int t = 0; t < 50 && got_q.size() < 1; t++) tick();
    checks++;
    if (got_q.size() != 1 || got_q[0].d !== 64'hC || got_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL war_data got n=%0d d=%h exp n=1 d=%h", got_q.size(),
               (got_q.size() > 0) ? got_q[0].d : 64'h0, 64'hC);
    end
    exp_q.delete();
    got_q.delete();
    repeat (3) tick();
    // read waits behind one write, then collides with a younger write at the queue heads
    drive(1'b1, 12'h031, 64'h1, 1'b1, 12'h032, wa_ok, ra_ok);
    drive(1'b1, 12'h032, 64'h77, 1'b0, 12'h0, wa_ok, ra_ok);
    checks++;
    if (write_enable !== 1'b1 || write_address !== 12'h031) begin
      errors++;
      $display("FAIL coll_w1 got we=%b a=%h exp 1 031", write_enable, write_address);
    end
    tick();
    checks++;
    if (read_enable !== 1'b1 || read_address !== 12'h032 || write_enable !== 1'b0) begin
      errors++;
      $display("FAIL coll_hold got re=%b ra=%h we=%b exp 1 032 0", read_enable, read_address, write_enable);
    end
    tick();
    checks++;
    if (write_enable !== 1'b1 || write_address !== 12'h032 || data_in !== 64'h77) begin
      errors++;
      $display("FAIL coll_w2 got we=%b a=%h d=%h exp 1 032 77", write_enable, write_address, data_in);
    end
    for (int t = 0; t < 50 && got_q.size() < 1; t++) tick();
    checks++;
    if (got_q.size() != 1 || got_q[0].d !== 64'h55 || got_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL coll_data got n=%0d d=%h exp n=1 d=%h", got_q.size(),
               (got_q.size() > 0) ? got_q[0].d : 64'h0, 64'h55);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_backpressure();
    logic        wa_ok, ra_ok;
    int          base;
    logic [63:0] held;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 12'h100 + 12'(i), {32'hCAFE_0000 + 32'(i), 32'(i * 7)}, 1'b0, 12'h0, wa_ok, ra_ok);
    end
    repeat (4) tick();
    rsp_ready = 1'b0;
    base = re_cnt;
    for (int i = 0; i < 8; i++) begin
      ra_ok = 1'b0;
      for (int t = 0; t < 40 && !ra_ok; t++) drive(1'b0, 12'h0, 64'h0, 1'b1, 12'h100 + 12'(i), wa_ok, ra_ok);
      checks++;
      if (ra_ok !== 1'b1) begin
        errors++;
        $display("FAIL bp_accept[%0d] got 0 exp 1", i);
      end
    end
    repeat (6) tick();
    checks++;
    if (re_cnt - base != 4 || rd_ready !== 1'b0 || rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_stall got pulses=%0d rd_ready=%b rsp_valid=%b exp 4 0 1",
               re_cnt - base, rd_ready, rsp_valid);
    end
    held = rsp_data;
    repeat (3) tick();
    checks++;
    if (rsp_data !== held || rsp_addr !== 12'h100 || held !== exp_q[0].d) begin
      errors++;
      $display("FAIL bp_hold got d=%h a=%h exp d=%h a=100", rsp_data, rsp_addr, exp_q[0].d);
    end
    rsp_ready = 1'b1;
    for (int t = 0; t < 100 && got_q.size() < exp_q.size(); t++) tick();
    checks++;
    if (got_q.size() != 8) begin
      errors++;
      $display("FAIL bp_count got %0d exp 8", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL bp_rsp[%0d] got %h/%h exp %h/%h", i, got_q[i].a, got_q[i].d, exp_q[i].a, exp_q[i].d);
      end
    end
    repeat (3) tick();
    checks++;
    if (re_cnt - base != 8 || idle !== 1'b1) begin
      errors++;
      $display("FAIL bp_end got pulses=%0d idle=%b exp 8 1", re_cnt - base, idle);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_random();
    logic        wa_ok, ra_ok, wv, rv;
    logic [11:0] wa, ra;
    for (int i = 0; i < 16; i++) begin
      wa_ok = 1'b0;
      for (int t = 0; t < 20 && !wa_ok; t++) drive(1'b1, 12'(i), {$urandom, $urandom}, 1'b0, 12'h0, wa_ok, ra_ok);
    end
    for (int c = 0; c < 400; c++) begin
      rsp_ready = ($urandom_range(3) != 0);
      wv = 1'($urandom_range(1));
      rv = 1'($urandom_range(1));
      wa = 12'($urandom_range(15));
      ra = 12'($urandom_range(15));
      // never overwrite an address an older read is still waiting to return
      for (int k = got_q.size(); k < exp_q.size(); k++) if (exp_q[k].a == wa) wv = 1'b0;
      drive(wv, wa, {$urandom, $urandom}, rv, ra, wa_ok, ra_ok);
    end
    rsp_ready = 1'b1;
    for (int t = 0; t < 200 && got_q.size() < exp_q.size(); t++) tick();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rand_rsp[%0d] got %h/%h exp %h/%h", i, got_q[i].a, got_q[i].d, exp_q[i].a, exp_q[i].d);
      end
    end
    repeat (4) tick();
    checks++;
    if (idle !== 1'b1) begin
      errors++;
      $display("FAIL rand_idle got %b exp 1", idle);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset_inflight();
    logic wa_ok, ra_ok;
    int   seen;
    drive(1'b0, 12'h0, 64'h0, 1'b1, 12'h005, wa_ok, ra_ok);
    drive(1'b0, 12'h0, 64'h0, 1'b1, 12'h010, wa_ok, ra_ok);
    drive(1'b0, 12'h0, 64'h0, 1'b1, 12'h020, wa_ok, ra_ok);
    checks++;
    if (exp_q.size() != 3 || idle !== 1'b0) begin
      errors++;
      $display("FAIL flush_setup got reads=%0d idle=%b exp 3 0", exp_q.size(), idle);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    got_q.delete();
    seen = 0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (rsp_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0 || got_q.size() != 0) begin
      errors++;
      $display("FAIL flush_rsp got valid_cycles=%0d rsps=%0d exp 0 0", seen, got_q.size());
    end
    checks++;
    if (idle !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle got %b exp 1", idle);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 64'h0;
    test_reset();
    test_write_read();
    test_same_edge();
    test_collision();
    test_backpressure();
    test_random();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
